// File: rtl/decrypted_instr_queue.sv
// Prefetch queue between the crypt unit and decode: holds decrypted words
// in program order and drops stale words that arrive after a redirect.
//
// Ports:
//   clk, Rstn                       clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc    word from the crypt unit
//   out_valid/out_ready/out_instr/out_pc head entry to decode
//   flush/flush_pc                  redirect; new expected fetch PC
//   count                           current occupancy
//   stale_drops                     saturating count of PC-mismatch drops
module decrypted_instr_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       Rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 stale_drops
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   exp_pc_q, exp_pc_d;
    logic [7:0]    stale_q, stale_d;

    logic hs_in;
    logic pc_ok;
    logic push;
    logic stale;
    logic pop;

    // Handshake flags come from registered count only.
    assign in_ready    = (count_q != FULL);
    assign out_valid   = (count_q != '0);
    assign out_instr   = instr_q[head_q];
    assign out_pc      = pc_q[head_q];
    assign count       = count_q;
    assign stale_drops = stale_q;

    // A flush swallows any word handshaken in the same cycle.
    assign hs_in = in_valid && in_ready;
    assign pc_ok = (in_pc == exp_pc_q);
    assign push  = hs_in && !flush && pc_ok;
    assign stale = hs_in && !flush && !pc_ok;
    assign pop   = out_valid && out_ready && !flush;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        exp_pc_d = exp_pc_q;
        stale_d  = stale_q;
        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            exp_pc_d = flush_pc;
        end else begin
            if (push) begin
                tail_d   = tail_q + AW'(1);
                exp_pc_d = exp_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (stale && stale_q != 8'hFF) begin
                stale_d = stale_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge Rstn) begin
        if (!Rstn) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            exp_pc_q <= RESET_PC;
            stale_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            exp_pc_q <= exp_pc_d;
            stale_q  <= stale_d;
            if (push) begin
                pc_q[tail_q]    <= in_pc;
                instr_q[tail_q] <= in_instr;
            end
        end
    end

endmodule

// File: tb/tb_decrypted_instr_queue.sv
// Scoreboard bench for decrypted_instr_queue: a queue-based model predicts
// accepted words, a negedge monitor pops and compares on every output handshake.
module tb_decrypted_instr_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        Rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  count;
    logic [7:0]  stale_drops;

    decrypted_instr_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .Rstn        (Rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .count       (count),
        .stale_drops (stale_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of expected {pc, instr} plus an occupancy
    // counter, updated from the queue's rules at each clock edge.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    int          m_cnt;
    logic [31:0] m_exp;
    int          m_stale;
    bit          m_rdy;
    bit          m_pop;
    ent_t        e;

    always @(posedge clk or negedge Rstn) begin
        if (!Rstn) begin
            sb.delete();
            m_cnt   = 0;
            m_exp   = RESET_PC;
            m_stale = 0;
        end else begin
            m_rdy = (m_cnt != DEPTH);
            m_pop = (m_cnt != 0) && out_ready && !flush;
            if (flush) begin
                sb.delete();
                m_cnt = 0;
                m_exp = flush_pc;
            end else begin
                if (in_valid && m_rdy) begin
                    if (in_pc == m_exp) begin
                        sb.push_back('{pc: in_pc, instr: in_instr});
                        m_exp = m_exp + 32'd4;
                        m_cnt++;
                    end else if (m_stale < 255) begin
                        m_stale++;
                    end
                end
                if (m_pop) m_cnt--;
            end
        end
    end

    // Monitor: mid-cycle compare of status and of every consumed head entry.
    always @(negedge clk) begin
        if (Rstn) begin
            check("count", 32'(count), 32'(m_cnt));
            check("in_ready", 32'(in_ready), 32'(m_cnt != DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_cnt != 0));
            check("stale_drops", 32'(stale_drops), 32'(m_stale));
            if (out_valid && out_ready && !flush) begin
                n_pop++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: got pc %h expected no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = $urandom;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready 0 expected 1 for pc %h", pc);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        tick();
        flush    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        check({tag, "_out_pc"}, out_pc, 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_stale"}, 32'(stale_drops), 32'd0);
    endtask

    int s0;
    int p0;

    initial begin
        Rstn      = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        flush_pc  = '0;
        #2;
        check_reset_outputs("rst");
        #10;
        Rstn = 1'b1;
        tick();

        // In-order fill, then a 5th word held until a pop frees a slot.
        send(32'd0);
        send(32'd4);
        send(32'd8);
        send(32'd12);
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_out_pc", out_pc, 32'd0);
        in_valid = 1'b1;
        in_pc    = 32'd16;
        in_instr = $urandom;
        tick();
        tick();
        check("hold_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        check("popfull_in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check("afterpop_in_ready", 32'(in_ready), 32'd1);
        check("afterpop_count", 32'(count), 32'd3);
        tick();
        in_valid = 1'b0;
        check("push5_count", 32'(count), 32'd4);
        check("push5_head", out_pc, 32'd4);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);

        // Streaming: one word in and one out every cycle.
        do_flush(32'd0);
        out_ready = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 20; i++) send(32'(i * 4));
        check("stream_count", 32'(count), 32'd1);
        tick();
        check("stream_pops", 32'(n_pop - p0), 32'd20);
        out_ready = 1'b0;

        // Flush with stale words still draining.
        do_flush(32'd0);
        send(32'd0);
        send(32'd4);
        send(32'd8);
        check("pre_flush_count", 32'(count), 32'd3);
        s0 = int'(stale_drops);
        do_flush(32'h100);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        send(32'd12);
        send(32'd16);
        send(32'h100);
        check("stale_two", 32'(stale_drops), 32'(s0 + 2));
        check("redirect_count", 32'(count), 32'd1);
        check("redirect_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush coinciding with both handshakes.
        send(32'h104);
        send(32'h108);
        s0        = int'(stale_drops);
        in_valid  = 1'b1;
        in_pc     = 32'h10C;
        in_instr  = $urandom;
        out_ready = 1'b1;
        do_flush(32'h200);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fhs_count", 32'(count), 32'd0);
        check("fhs_stale", 32'(stale_drops), 32'(s0));
        send(32'h10C);
        check("fhs_old_pc_stale", 32'(stale_drops), 32'(s0 + 1));
        send(32'h200);
        check("fhs_new_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges at count=3.
        send(32'h204);
        send(32'h208);
        send(32'h20C);
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        Rstn = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        #2;
        Rstn = 1'b1;
        tick();

        // Saturation of the stale counter.
        for (int i = 0; i < 300; i++) send(32'h1000 + 32'(i * 4));
        check("stale_sat", 32'(stale_drops), 32'd255);
        check("sat_count", 32'(count), 32'd0);

        // Random traffic.
        do_flush(32'h0);
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_pc     = (($urandom % 5) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_exp;
            in_instr  = $urandom;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            flush_pc  = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("final_count", 32'(count), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decrypted_instr_queue.md
# decrypted_instr_queue

Prefetch buffer that sits directly downstream of the instruction crypt unit and upstream of the core's decode stage. It accepts decrypted instruction words tagged with their PC, and holds up to DEPTH of them in program order. It presents them to decode over a valid/ready handshake. On a control-flow flush it discards both its buffered contents and any stale words still draining out of the crypt pipeline.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: expected PC after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  crypt unit presents a decrypted word.
- in_ready  output  1  queue can take a word this cycle.
- in_instr  input  32  decrypted instruction.
- in_pc  input  32  PC of in_instr.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_instr  output  32  head instruction.
- out_pc  output  32  head PC.
- flush  input  1  redirect from execute; single-cycle pulse or level.
- flush_pc  input  32  new fetch target; sampled when flush=1.
- count  output  log2(DEPTH)+1  current occupancy.
- stale_drops  output  8  saturating count of words discarded for PC mismatch.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {pc, instr}. It uses head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- The exp_pc register holds the PC the next accepted word must carry.
- in_ready = (count != DEPTH). It does not depend on in_pc or flush.
- A handshake occurs when in_valid && in_ready. It is classified in this priority order:
  - flush=1: the word is discarded. No push, and stale_drops is unchanged.
  - in_pc == exp_pc: push at tail, then tail+1 and exp_pc += 4 (mod 2^32).
  - in_pc != exp_pc: stale. The word is discarded and stale_drops increments, saturating at 255.
- out_valid = (count != 0). out_instr and out_pc read the head entry combinationally.
- A pop occurs when out_valid && out_ready && !flush. It advances head by 1.
- Push and pop in the same cycle leave count unchanged. Since in_ready=0 when full, push-on-full never happens. A pop on a full queue makes in_ready=1 only in the following cycle, so there is no bypass.
- Flush has highest priority:
  - head, tail and count are set to 0, and exp_pc is set to flush_pc.
  - Any simultaneous push or pop is cancelled.
  - stale_drops is retained.
  - Entry contents are not cleared.
- Rstn=0 immediately, without waiting for a clock edge:
  - clears head, tail, count and stale_drops;
  - clears all entries to 0;
  - sets exp_pc to RESET_PC.
- Reset mid-transfer loses any word being handshaken in that cycle.

## Timing
- Reset values of the outputs:
  - out_valid=0, out_instr=32'h0, out_pc=32'h0;
  - in_ready=1, count=0, stale_drops=0.
- Latency: a word pushed at edge N appears on out_instr/out_pc with out_valid=1 after edge N (visible in cycle N+1). The minimum in-to-out latency is 1 cycle. There is no combinational in-to-out path.
- Throughput: 1 word per cycle sustained when count is between 1 and DEPTH-1.
- A flush asserted in cycle N produces out_valid=0 and count=0 in cycle N+1. The first word accepted with in_pc==flush_pc can be pushed in cycle N+1.
- in_ready and out_valid are derived from registered count only.

## Test plan
- **Reset, then in-order fill:** release Rstn, then present pc 0,4,8,12 with out_ready=0.
  - The words are accepted in consecutive cycles, giving count=4 and in_ready=0.
  - A 5th word at pc 16 is held until a pop.
  - out_pc=0 throughout.
- **Streaming:** in_valid=1 and out_ready=1 every cycle for 20 words starting at pc 0.
  - out_pc equals 0,4,…,76, each exactly 1 cycle after its input.
  - count stays at 1 and no word is lost.
- **Full with simultaneous pop:** at count=4, drive out_ready=1 and in_valid=1.
  - The pop occurs, and in_ready is 0 that cycle and 1 the next.
  - The 5th word is pushed one cycle later, and ordering is preserved.
- **Flush and stale drain:** queue holds pc 0,4,8; pulse flush with flush_pc=0x100; then present pc 12,16,0x100.
  - count=0 after the flush.
  - pc 12 and 16 are dropped, so stale_drops=2.
  - 0x100 is pushed, and out_pc=0x100 the following cycle.
- **Flush with in and out handshakes in the same cycle:** both handshakes occur in the flush cycle.
  - Neither takes effect, count=0, and stale_drops is unchanged.
- **Async reset mid-stream and saturation:**
  - Assert Rstn between clock edges at count=3: outputs go to their reset values immediately.
  - Separately, feed 300 mismatched PCs: stale_drops stops at 255.
